// File: rtl/load_store_mem_ctrl.sv
// MEM-stage load/store responder driving a byte-wide synchronous data RAM.
// Ports: clk, rst_n | mem_addr_i, mem_aluop_i, rt_data_i (request) |
//   load_store_mem_ctrl_done, rdata (completion, load data) |
//   ram_addr_o, ram_we_o, ram_wdata_o, ram_rdata_i (RAM port).
module load_store_mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       mem_addr_i,
   input  logic [7:0]        mem_aluop_i,
   input  logic [31:0]       rt_data_i,
   output logic              load_store_mem_ctrl_done,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic [7:0]        ram_wdata_o,
   input  logic [7:0]        ram_rdata_i
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_TAIL,
      WR,
      DONE
   } state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [1:0]  last;
   logic [31:0] data_q;

   logic        is_load;
   logic        is_store;
   logic [1:0]  size_m1;
   logic [1:0]  cnt_prev;
   logic [1:0]  cnt_next;

   // Only the low ADDR_W address bits reach the RAM.
   logic unused_addr_hi;
   assign unused_addr_hi = ^mem_addr_i[31:ADDR_W];

   assign cnt_prev = cnt - 2'd1;
   assign cnt_next = cnt + 2'd1;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size_m1  = 2'd0;
      case (mem_aluop_i)
         EXE_LB_OP, EXE_LBU_OP: begin
            is_load = 1'b1;
            size_m1 = 2'd0;
         end
         EXE_LH_OP, EXE_LHU_OP: begin
            is_load = 1'b1;
            size_m1 = 2'd1;
         end
         EXE_LW_OP: begin
            is_load = 1'b1;
            size_m1 = 2'd3;
         end
         EXE_SB_OP: begin
            is_store = 1'b1;
            size_m1  = 2'd0;
         end
         EXE_SH_OP: begin
            is_store = 1'b1;
            size_m1  = 2'd1;
         end
         EXE_SW_OP: begin
            is_store = 1'b1;
            size_m1  = 2'd3;
         end
         default: begin
            is_load  = 1'b0;
            is_store = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                    <= IDLE;
         cnt                      <= 2'd0;
         last                     <= 2'd0;
         data_q                   <= 32'd0;
         load_store_mem_ctrl_done <= 1'b0;
         rdata                    <= 32'd0;
         ram_addr_o               <= '0;
         ram_we_o                 <= 1'b0;
         ram_wdata_o              <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt  <= 2'd0;
               last <= size_m1;
               if (is_load) begin
                  state      <= RD;
                  rdata      <= 32'd0;
                  ram_addr_o <= mem_addr_i[ADDR_W-1:0];
               end else if (is_store) begin
                  state       <= WR;
                  data_q      <= rt_data_i;
                  ram_addr_o  <= mem_addr_i[ADDR_W-1:0];
                  ram_we_o    <= 1'b1;
                  ram_wdata_o <= rt_data_i[7:0];
               end
            end
            RD: begin
               // RAM data lags its address by one cycle.
               if (cnt != 2'd0)
                  rdata[{cnt_prev, 3'b000} +: 8] <= ram_rdata_i;
               if (cnt == last) begin
                  state <= RD_TAIL;
               end else begin
                  cnt        <= cnt_next;
                  ram_addr_o <= ram_addr_o + ADDR_ONE;
               end
            end
            RD_TAIL: begin
               rdata[{last, 3'b000} +: 8] <= ram_rdata_i;
               state                    <= DONE;
               load_store_mem_ctrl_done <= 1'b1;
            end
            WR: begin
               if (cnt == last) begin
                  state                    <= DONE;
                  ram_we_o                 <= 1'b0;
                  load_store_mem_ctrl_done <= 1'b1;
               end else begin
                  cnt         <= cnt_next;
                  ram_addr_o  <= ram_addr_o + ADDR_ONE;
                  ram_wdata_o <= data_q[{cnt_next, 3'b000} +: 8];
               end
            end
            DONE: begin
               state                    <= IDLE;
               ram_we_o                 <= 1'b0;
               load_store_mem_ctrl_done <= 1'b0;
            end
            default: begin
               state                    <= IDLE;
               ram_we_o                 <= 1'b0;
               load_store_mem_ctrl_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_mem_ctrl.sv
// Directed bench for load_store_mem_ctrl with a behavioural byte RAM.
// Ports: none (self-contained, drives clock, reset, request and RAM).
module tb_load_store_mem_ctrl;

   localparam logic [7:0] LB  = 8'b1110_0000;
   localparam logic [7:0] LW  = 8'b1110_0011;
   localparam logic [7:0] LHU = 8'b1110_0101;
   localparam logic [7:0] SB  = 8'b1110_1000;
   localparam logic [7:0] SH  = 8'b1110_1001;
   localparam logic [7:0] SW  = 8'b1110_1011;
   localparam logic [7:0] NOP = 8'b0010_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem_addr_i;
   logic [7:0]  mem_aluop_i;
   logic [31:0] rt_data_i;
   logic        done;
   logic [31:0] rdata;
   logic [16:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   logic [7:0]  mem [0:131071];
   logic        pl_en;
   logic [16:0] pl_a;
   logic [7:0]  pl_d;

   int total = 0;
   int bad = 0;

   logic [16:0] a_log [0:12];
   logic        we_log [0:12];
   logic [7:0]  wd_log [0:12];
   int          done_cyc;
   int          done_cnt;
   int          we_cnt;
   logic [31:0] rd_done;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we)
         mem[ram_addr] <= ram_wdata;
      else if (pl_en)
         mem[pl_a] <= pl_d;
      ram_rdata <= mem[ram_addr];
   end

   load_store_mem_ctrl #(.ADDR_W(17)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .mem_addr_i               (mem_addr_i),
      .mem_aluop_i              (mem_aluop_i),
      .rt_data_i                (rt_data_i),
      .load_store_mem_ctrl_done (done),
      .rdata                    (rdata),
      .ram_addr_o               (ram_addr),
      .ram_we_o                 (ram_we),
      .ram_wdata_o              (ram_wdata),
      .ram_rdata_i              (ram_rdata)
   );

   task automatic poke(input logic [16:0] a, input logic [7:0] d);
      @(posedge clk);
      #1;
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = d;
      @(posedge clk);
      #1;
      pl_en = 1'b0;
   endtask

   // Presents a request in cycle 0, retires it in the done cycle, logs 12 cycles.
   task automatic run_req(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] d);
      @(posedge clk);
      #1;
      mem_aluop_i = op;
      mem_addr_i  = a;
      rt_data_i   = d;
      done_cyc = -1;
      done_cnt = 0;
      we_cnt   = 0;
      rd_done  = 32'hx;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         a_log[c]  = ram_addr;
         we_log[c] = ram_we;
         wd_log[c] = ram_wdata;
         if (ram_we) we_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               rd_done  = rdata;
            end
            mem_aluop_i = NOP;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      total += 5;
      if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
      if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
      if (ram_addr !== 17'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", ram_addr); end
      if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", ram_we); end
      if (ram_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata got=%h want=0", ram_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_lw;
      poke(17'h100, 8'h11);
      poke(17'h101, 8'h22);
      poke(17'h102, 8'h33);
      poke(17'h103, 8'h44);
      run_req(LW, 32'h100, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         total++;
         if (a_log[i] !== 17'h100 + 17'(i - 1)) begin
            bad++;
            $display("FAIL lw_addr%0d got=%h want=%h", i, a_log[i], 17'h100 + 17'(i - 1));
         end
      end
      total += 4;
      if (done_cyc !== 6) begin bad++; $display("FAIL lw_done_cyc got=%0d want=6", done_cyc); end
      if (done_cnt !== 1) begin bad++; $display("FAIL lw_done_cnt got=%0d want=1", done_cnt); end
      if (rd_done !== 32'h44332211) begin bad++; $display("FAIL lw_rdata got=%h want=44332211", rd_done); end
      if (we_cnt !== 0) begin bad++; $display("FAIL lw_we got=%0d want=0", we_cnt); end
   endtask

   task automatic test_sh;
      poke(17'h202, 8'h5A);
      run_req(SH, 32'h200, 32'h0000ABCD);
      total += 8;
      if (we_log[1] !== 1'b1 || a_log[1] !== 17'h200 || wd_log[1] !== 8'hCD) begin
         bad++;
         $display("FAIL sh_c1 got=%b/%h/%h want=1/00200/cd", we_log[1], a_log[1], wd_log[1]);
      end
      if (we_log[2] !== 1'b1 || a_log[2] !== 17'h201 || wd_log[2] !== 8'hAB) begin
         bad++;
         $display("FAIL sh_c2 got=%b/%h/%h want=1/00201/ab", we_log[2], a_log[2], wd_log[2]);
      end
      if (we_log[3] !== 1'b0) begin bad++; $display("FAIL sh_we_c3 got=%b want=0", we_log[3]); end
      if (done_cyc !== 3) begin bad++; $display("FAIL sh_done_cyc got=%0d want=3", done_cyc); end
      if (we_cnt !== 2) begin bad++; $display("FAIL sh_we_cnt got=%0d want=2", we_cnt); end
      if (mem[17'h200] !== 8'hCD) begin bad++; $display("FAIL sh_m200 got=%h want=cd", mem[17'h200]); end
      if (mem[17'h201] !== 8'hAB) begin bad++; $display("FAIL sh_m201 got=%h want=ab", mem[17'h201]); end
      if (mem[17'h202] !== 8'h5A) begin bad++; $display("FAIL sh_m202 got=%h want=5a", mem[17'h202]); end
   endtask

   task automatic test_lb;
      poke(17'h50, 8'h80);
      poke(17'h51, 8'h7E);
      run_req(LB, 32'h50, 32'h0);
      total += 3;
      if (done_cyc !== 3) begin bad++; $display("FAIL lb_done_cyc got=%0d want=3", done_cyc); end
      if (rd_done !== 32'h00000080) begin bad++; $display("FAIL lb_rdata got=%h want=00000080", rd_done); end
      if (rdata !== 32'h00000080) begin bad++; $display("FAIL lb_hold got=%h want=00000080", rdata); end
      run_req(SB, 32'h60, 32'h000000FF);
      total++;
      if (rdata !== 32'h00000080) begin bad++; $display("FAIL lb_after_sb got=%h want=00000080", rdata); end
      run_req(LHU, 32'h50, 32'h0);
      total += 2;
      if (done_cyc !== 4) begin bad++; $display("FAIL lhu_done_cyc got=%0d want=4", done_cyc); end
      if (rd_done !== 32'h00007E80) begin bad++; $display("FAIL lhu_rdata got=%h want=00007e80", rd_done); end
   endtask

   task automatic test_wrap;
      logic [16:0] exp_a [0:3];
      exp_a[0] = 17'h1FFFE;
      exp_a[1] = 17'h1FFFF;
      exp_a[2] = 17'h00000;
      exp_a[3] = 17'h00001;
      run_req(SW, 32'h0001FFFE, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (a_log[i+1] !== exp_a[i] || we_log[i+1] !== 1'b1) begin
            bad++;
            $display("FAIL wrap_addr%0d got=%h/%b want=%h/1", i, a_log[i+1], we_log[i+1], exp_a[i]);
         end
      end
      total += 4;
      if (done_cyc !== 5) begin bad++; $display("FAIL sw_done_cyc got=%0d want=5", done_cyc); end
      if (mem[17'h1FFFE] !== 8'hEF) begin bad++; $display("FAIL wrap_m0 got=%h want=ef", mem[17'h1FFFE]); end
      if (mem[17'h00000] !== 8'hAD) begin bad++; $display("FAIL wrap_m2 got=%h want=ad", mem[17'h00000]); end
      if (mem[17'h00001] !== 8'hDE) begin bad++; $display("FAIL wrap_m3 got=%h want=de", mem[17'h00001]); end
      run_req(LW, 32'h0001FFFE, 32'h0);
      total++;
      if (rd_done !== 32'hDEADBEEF) begin bad++; $display("FAIL wrap_lw got=%h want=deadbeef", rd_done); end
   endtask

   task automatic test_reset_mid;
      int dn;
      poke(17'h301, 8'h99);
      @(posedge clk);
      #1;
      mem_aluop_i = SW;
      mem_addr_i  = 32'h300;
      rt_data_i   = 32'h11223344;
      @(posedge clk);
      #1;
      total++;
      if (ram_we !== 1'b1 || ram_wdata !== 8'h44) begin
         bad++;
         $display("FAIL mid_c1 got=%b/%h want=1/44", ram_we, ram_wdata);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total += 4;
      if (ram_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%b want=0", ram_we); end
      if (ram_addr !== 17'd0) begin bad++; $display("FAIL mid_addr got=%h want=0", ram_addr); end
      if (rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata got=%h want=0", rdata); end
      if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", done); end
      mem_aluop_i = NOP;
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      total += 3;
      if (dn !== 0) begin bad++; $display("FAIL mid_nodone got=%0d want=0", dn); end
      if (mem[17'h300] !== 8'h44) begin bad++; $display("FAIL mid_m300 got=%h want=44", mem[17'h300]); end
      if (mem[17'h301] !== 8'h99) begin bad++; $display("FAIL mid_m301 got=%h want=99", mem[17'h301]); end
   endtask

   task automatic test_back_to_back;
      int dn;
      int wn;
      int d1;
      int d2;
      @(posedge clk);
      #1;
      mem_aluop_i = NOP;
      mem_addr_i  = 32'h400;
      rt_data_i   = 32'h5A;
      dn = 0;
      wn = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (done) dn++;
         if (ram_we) wn++;
      end
      total += 2;
      if (dn !== 0) begin bad++; $display("FAIL nop_done got=%0d want=0", dn); end
      if (wn !== 0) begin bad++; $display("FAIL nop_we got=%0d want=0", wn); end
      mem_aluop_i = SB;
      dn = 0;
      d1 = -1;
      d2 = -1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dn++;
            if (d1 < 0) begin
               d1 = c;
               mem_addr_i = 32'h401;
               rt_data_i  = 32'hA5;
            end else if (d2 < 0) begin
               d2 = c;
               mem_aluop_i = NOP;
            end
         end
      end
      total += 5;
      if (d1 !== 2) begin bad++; $display("FAIL b2b_d1 got=%0d want=2", d1); end
      if (d2 !== 5) begin bad++; $display("FAIL b2b_d2 got=%0d want=5", d2); end
      if (dn !== 2) begin bad++; $display("FAIL b2b_cnt got=%0d want=2", dn); end
      if (mem[17'h400] !== 8'h5A) begin bad++; $display("FAIL b2b_m400 got=%h want=5a", mem[17'h400]); end
      if (mem[17'h401] !== 8'hA5) begin bad++; $display("FAIL b2b_m401 got=%h want=a5", mem[17'h401]); end
   endtask

   initial begin
      rst_n       = 1'b0;
      mem_addr_i  = 32'd0;
      mem_aluop_i = NOP;
      rt_data_i   = 32'd0;
      pl_en       = 1'b0;
      pl_a        = 17'd0;
      pl_d        = 8'd0;
      test_reset;
      test_lw;
      test_sh;
      test_lb;
      test_wrap;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
